cpu_run_controller: RTL and testbench

- Sequences the single-cycle MIPS core.
- Streams a program from a host into instruction memory, then pulses the core's PC reset.
- Drives the core's enablePC for free-run or single-step execution.
- Stops execution on host request, PC breakpoint, or a halt instruction. Sits beside topLevel and replaces the bench-driven enablePC/reset sequence.

---
 rtl/cpu_run_controller.sv | 137 +++++++++++++
 tb/tb_cpu_run_controller.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_controller.sv
// Run controller for the single-cycle MIPS core: streams a host program into
// instruction memory, pulses the core PC reset, then gates enablePC for run/step.
module cpu_run_controller #(
  parameter int unsigned ADDR_W     = 8,
  parameter logic [31:0] HALT_INSTR = 32'hFFFF_FFFF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_start,
  input  logic              host_valid,
  input  logic [31:0]       host_data,
  input  logic              host_last,
  output logic              host_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              enablePC,
  input  logic              run,
  input  logic              step,
  input  logic              halt_req,
  input  logic              bp_enable,
  input  logic [31:0]       bp_addr,
  input  logic [31:0]       pc,
  input  logic [31:0]       instruction,
  output logic [2:0]        state,
  output logic [1:0]        halt_cause,
  output logic              load_overflow,
  output logic [31:0]       cycle_count
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_PCRST  = 3'd2;
  localparam logic [2:0] S_READY  = 3'd3;
  localparam logic [2:0] S_RUN    = 3'd4;
  localparam logic [2:0] S_STEP   = 3'd5;
  localparam logic [2:0] S_HALTED = 3'd6;

  localparam logic [1:0] C_NONE  = 2'd0;
  localparam logic [1:0] C_HOST  = 2'd1;
  localparam logic [1:0] C_BP    = 2'd2;
  localparam logic [1:0] C_INSTR = 2'd3;

  logic [2:0]        state_nxt;
  logic [1:0]        halt_cond;
  logic [ADDR_W-1:0] load_addr;
  logic              bp_skip;
  logic              exec;
  logic              accept;
  logic              resuming;

  // Halt check, highest priority first; only meaningful while executing
  always_comb begin
    halt_cond = C_NONE;
    if (halt_req)
      halt_cond = C_HOST;
    else if (bp_enable && (pc == bp_addr) && !bp_skip)
      halt_cond = C_BP;
    else if (instruction == HALT_INSTR)
      halt_cond = C_INSTR;
  end

  assign exec       = (state == S_RUN) || (state == S_STEP);
  assign enablePC   = exec && (halt_cond == C_NONE);
  assign host_ready = (state == S_LOAD);
  assign accept     = host_ready && host_valid;
  assign cpu_reset  = (state == S_PCRST);
  assign resuming   = (state_nxt == S_RUN) || (state_nxt == S_STEP);

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_READY, S_HALTED: begin
        if (load_start)
          state_nxt = S_LOAD;
        else if (run)
          state_nxt = S_RUN;
        else if (step)
          state_nxt = S_STEP;
      end
      S_LOAD:  if (accept && host_last) state_nxt = S_PCRST;
      S_PCRST: state_nxt = S_READY;
      S_RUN:   if (halt_cond != C_NONE) state_nxt = S_HALTED;
      S_STEP:  state_nxt = (halt_cond != C_NONE) ? S_HALTED : S_READY;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      imem_we       <= 1'b0;
      imem_addr     <= '0;
      imem_wdata    <= '0;
      load_addr     <= '0;
      load_overflow <= 1'b0;
      halt_cause    <= C_NONE;
      bp_skip       <= 1'b0;
      cycle_count   <= '0;
    end else begin
      state   <= state_nxt;
      imem_we <= accept;

      // Write port lags acceptance by one cycle; address wraps and flags it
      if (accept) begin
        imem_addr  <= load_addr;
        imem_wdata <= host_data;
        load_addr  <= load_addr + ADDR_W'(1);
        if (&load_addr)
          load_overflow <= 1'b1;
      end
      if ((state_nxt == S_LOAD) && (state != S_LOAD)) begin
        load_addr     <= '0;
        load_overflow <= 1'b0;
      end

      if (exec && (halt_cond != C_NONE))
        halt_cause <= halt_cond;
      else if (((state == S_HALTED) && (state_nxt != S_HALTED)) || (state == S_PCRST))
        halt_cause <= C_NONE;

      // Resuming from a breakpoint must not re-trigger on the same pc
      if ((state == S_HALTED) && (halt_cause == C_BP) && resuming)
        bp_skip <= 1'b1;
      else if (exec)
        bp_skip <= 1'b0;

      if (state == S_PCRST)
        cycle_count <= '0;
      else if (enablePC && (cycle_count != 32'hFFFF_FFFF))
        cycle_count <= cycle_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_cpu_run_controller.sv
// Randomized scoreboard bench for cpu_run_controller: the driver pushes per-cycle
// expectations and imem writes derived from scenario rules; a monitor pops and compares.
module tb_cpu_run_controller;

  localparam int unsigned AW   = 2;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;
  localparam logic [31:0] FAR  = 32'h8000_0000;
  localparam logic [2:0] IDLE = 3'd0, LOAD = 3'd1, PCRST = 3'd2, READY = 3'd3,
                         RUN = 3'd4, STEP = 3'd5, HALTED = 3'd6;

  logic          clock = 1'b0;
  logic          reset;
  logic          load_start, host_valid, host_last, host_ready;
  logic [31:0]   host_data;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_reset, enablePC;
  logic          run, step, halt_req, bp_enable;
  logic [31:0]   bp_addr, pc, instruction;
  logic [2:0]    state;
  logic [1:0]    halt_cause;
  logic          load_overflow;
  logic [31:0]   cycle_count;

  cpu_run_controller #(.ADDR_W(AW), .HALT_INSTR(HALT)) dut (
    .clock(clock), .reset(reset), .load_start(load_start), .host_valid(host_valid),
    .host_data(host_data), .host_last(host_last), .host_ready(host_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_reset(cpu_reset), .enablePC(enablePC), .run(run), .step(step),
    .halt_req(halt_req), .bp_enable(bp_enable), .bp_addr(bp_addr), .pc(pc),
    .instruction(instruction), .state(state), .halt_cause(halt_cause),
    .load_overflow(load_overflow), .cycle_count(cycle_count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [2:0]  st;
    logic        en;
    logic [1:0]  cause;
    logic [31:0] cnt;
    logic        ovf;
  } exp_t;

  exp_t            cq[$];
  logic [AW+31:0]  wq[$];
  logic [31:0]     lw[$];
  int              checks = 0;
  int              errors = 0;
  int              rst_req = 0;
  int              rst_seen = 0;
  logic            done = 1'b0;
  event            rst_ev;

  // Model of the externally visible execution history
  logic [31:0] m_cnt;
  int          m_words;
  logic        m_ovf;
  logic [2:0]  m_st;
  logic [1:0]  m_cause;

  // Monitor: compares every cycle with a pending expectation, and every imem write
  initial begin : monitor
    exp_t           e;
    logic [AW+31:0] w;
    forever begin
      @(negedge clock or rst_ev);
      if (rst_req != rst_seen) begin
        rst_seen = rst_req;
        checks++;
        if (state !== IDLE || imem_we !== 1'b0 || host_ready !== 1'b0 || enablePC !== 1'b0 ||
            cpu_reset !== 1'b0 || load_overflow !== 1'b0 || halt_cause !== 2'd0 ||
            cycle_count !== 32'd0 || imem_addr !== '0 || imem_wdata !== 32'd0) begin
          errors++;
          $display("FAIL async_reset t=%0t: state=%0d we=%0b rdy=%0b en=%0b crst=%0b ovf=%0b cause=%0d cnt=%0d, required all zero",
                   $time, state, imem_we, host_ready, enablePC, cpu_reset, load_overflow, halt_cause, cycle_count);
        end
      end else begin
        if (cq.size() > 0) begin
          e = cq.pop_front();
          checks++;
          if (state !== e.st || enablePC !== e.en || halt_cause !== e.cause || cycle_count !== e.cnt ||
              load_overflow !== e.ovf || cpu_reset !== (e.st == PCRST) || host_ready !== (e.st == LOAD)) begin
            errors++;
            $display("FAIL ctl t=%0t: got state=%0d en=%0b cause=%0d cnt=%0d ovf=%0b crst=%0b rdy=%0b, required state=%0d en=%0b cause=%0d cnt=%0d ovf=%0b",
                     $time, state, enablePC, halt_cause, cycle_count, load_overflow, cpu_reset, host_ready,
                     e.st, e.en, e.cause, e.cnt, e.ovf);
          end
        end
        if (imem_we === 1'b1) begin
          checks++;
          if (wq.size() == 0) begin
            errors++;
            $display("FAIL imem_write t=%0t: unexpected write addr=%0d data=%h, required no write", $time, imem_addr, imem_wdata);
          end else begin
            w = wq.pop_front();
            if ({imem_addr, imem_wdata} !== w) begin
              errors++;
              $display("FAIL imem_write t=%0t: got addr=%0d data=%h, required addr=%0d data=%h",
                       $time, imem_addr, imem_wdata, w[AW+31:32], w[31:0]);
            end
          end
        end
        if (done) begin
          checks++;
          if (cq.size() != 0 || wq.size() != 0) begin
            errors++;
            $display("FAIL drain: pending ctl=%0d writes=%0d, required 0 and 0", cq.size(), wq.size());
          end
          $display("CHECKS %0d ERRORS %0d", checks, errors);
          $finish;
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  // One clock cycle: record what this cycle must show, then apply the edge's effect
  task automatic tick(input logic [2:0] st, input logic en, input logic [1:0] cause, input logic acc);
    exp_t e;
    e.st = st; e.en = en; e.cause = cause; e.cnt = m_cnt; e.ovf = m_ovf;
    cq.push_back(e);
    if (acc) wq.push_back({AW'(m_words % (1 << AW)), host_data});
    @(posedge clock); #1;
    if (acc) begin
      m_words++;
      if (m_words >= (1 << AW)) m_ovf = 1'b1;
    end
    if (en && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
    if (st == PCRST) m_cnt = 32'd0;
  endtask

  task automatic drive_conds(input logic [1:0] kind, input logic ovl);
    halt_req    = (kind == 2'd1);
    instruction = (kind == 2'd3 || (kind != 2'd0 && ovl)) ? HALT : ($urandom & 32'h7FFF_FFFF);
  endtask

  task automatic do_load();
    load_start = 1'b1; run = 1'($urandom_range(0, 1)); step = 1'($urandom_range(0, 1));
    tick(m_st, 1'b0, m_cause, 1'b0);
    load_start = 1'b0; run = 1'b0; step = 1'b0;
    m_words = 0; m_ovf = 1'b0;
    foreach (lw[i]) begin
      while ($urandom_range(0, 2) == 0) begin
        host_valid = 1'b0; host_last = 1'($urandom_range(0, 1)); host_data = $urandom;
        load_start = 1'($urandom_range(0, 1));
        tick(LOAD, 1'b0, 2'd0, 1'b0);
      end
      load_start = 1'b0;
      host_valid = 1'b1; host_data = lw[i]; host_last = (i == lw.size() - 1);
      tick(LOAD, 1'b0, 2'd0, 1'b1);
    end
    host_valid = 1'b0; host_last = 1'b0;
    tick(PCRST, 1'b0, 2'd0, 1'b0);
    m_st = READY; m_cause = 2'd0;
  endtask

  task automatic rand_load(input int n);
    lw.delete();
    for (int i = 0; i < n; i++) lw.push_back($urandom);
    do_load();
  endtask

  // Free-run for h clean cycles, halting with cause k on cycle h
  task automatic do_run(input int h, input logic [1:0] kind, input logic ovl, input logic [31:0] pc_in, input logic both);
    logic        skip;
    logic [31:0] pc0;
    logic [1:0]  k;
    skip = (m_st == HALTED) && (m_cause == 2'd2);
    k = (skip && kind == 2'd2) ? 2'd3 : kind;
    if (skip) pc0 = bp_addr;
    else begin
      pc0 = pc_in;
      bp_addr   = (k == 2'd2 || (k == 2'd1 && ovl)) ? pc0 + 32'(4 * h) : FAR;
      bp_enable = (k == 2'd2 || (k == 2'd1 && ovl)) ? 1'b1 : 1'($urandom_range(0, 1));
    end
    run = 1'b1; step = both; halt_req = 1'($urandom_range(0, 1)); pc = pc0;
    instruction = $urandom & 32'h7FFF_FFFF;
    tick(m_st, 1'b0, m_cause, 1'b0);
    for (int i = 0; i <= h; i++) begin
      run = 1'($urandom_range(0, 1)); step = 1'($urandom_range(0, 1));
      load_start = 1'($urandom_range(0, 1));
      pc = pc0 + 32'(4 * i);
      drive_conds((i == h) ? k : 2'd0, ovl && !skip);
      tick(RUN, (i != h), 2'd0, 1'b0);
    end
    run = 1'b0; step = 1'b0; load_start = 1'b0; halt_req = 1'b0;
    m_st = HALTED; m_cause = k;
  endtask

  task automatic do_step(input logic [1:0] kind);
    logic        skip;
    logic [31:0] pc0;
    logic [1:0]  k;
    skip = (m_st == HALTED) && (m_cause == 2'd2);
    k = (skip && kind == 2'd2) ? 2'd3 : kind;
    if (skip) pc0 = bp_addr;
    else begin
      pc0 = 32'(4 * $urandom_range(0, 200));
      bp_addr   = (k == 2'd2) ? pc0 : FAR;
      bp_enable = (k == 2'd2) ? 1'b1 : 1'($urandom_range(0, 1));
    end
    run = 1'b0; step = 1'b1; halt_req = 1'b0; pc = pc0;
    tick(m_st, 1'b0, m_cause, 1'b0);
    run = 1'($urandom_range(0, 1)); step = 1'($urandom_range(0, 1));
    drive_conds(k, 1'b0);
    tick(STEP, (k == 2'd0), 2'd0, 1'b0);
    run = 1'b0; step = 1'b0; halt_req = 1'b0;
    instruction = $urandom & 32'h7FFF_FFFF;
    if (k != 2'd0) begin m_st = HALTED; m_cause = k; end
    else begin m_st = READY; m_cause = 2'd0; end
  endtask

  initial begin : driver
    int r;
    reset = 1'b1; load_start = 1'b0; host_valid = 1'b0; host_data = 32'd0; host_last = 1'b0;
    run = 1'b0; step = 1'b0; halt_req = 1'b0; bp_enable = 1'b0; bp_addr = FAR;
    pc = 32'd0; instruction = 32'd0;
    m_cnt = 32'd0; m_words = 0; m_ovf = 1'b0; m_st = IDLE; m_cause = 2'd0;
    @(posedge clock); #1;
    tick(IDLE, 1'b0, 2'd0, 1'b0);
    reset = 1'b0;
    tick(IDLE, 1'b0, 2'd0, 1'b0);

    // Program load, run to halt instruction, breakpoint and resume
    lw.delete(); lw.push_back(32'h2008_0005); lw.push_back(32'h2108_0001); lw.push_back(32'hFFFF_FFFF);
    do_load();
    do_run(2, 2'd3, 1'b0, 32'd0, 1'b0);
    do_run(1, 2'd2, 1'b0, 32'd0, 1'b0);
    do_run(3, 2'd3, 1'b0, 32'd0, 1'b0);
    do_step(2'd0);
    do_run(2, 2'd1, 1'b1, 32'd40, 1'b1);
    do_step(2'd1);

    // Randomized mix of loads, runs and steps
    for (int it = 0; it < 60; it++) begin
      r = $urandom_range(0, 9);
      if (r < 2) rand_load($urandom_range(1, 6));
      else if (r < 6) do_run($urandom_range(0, 5), 2'($urandom_range(1, 3)), 1'($urandom_range(0, 1)),
                             32'(4 * $urandom_range(0, 200)), 1'($urandom_range(0, 1)));
      else begin
        r = $urandom_range(0, 6);
        do_step((r > 3) ? 2'd0 : 2'(r));
      end
    end

    // Asynchronous reset in the middle of a load
    load_start = 1'b1;
    tick(m_st, 1'b0, m_cause, 1'b0);
    load_start = 1'b0; m_words = 0; m_ovf = 1'b0;
    host_valid = 1'b1; host_data = $urandom; host_last = 1'b0;
    tick(LOAD, 1'b0, 2'd0, 1'b1);
    host_valid = 1'b0;
    #2 reset = 1'b1;
    #1 rst_req++; -> rst_ev;
    wq.delete();
    m_cnt = 32'd0; m_words = 0; m_ovf = 1'b0; m_st = IDLE; m_cause = 2'd0;
    @(posedge clock); #1;
    tick(IDLE, 1'b0, 2'd0, 1'b0);
    reset = 1'b0;
    tick(IDLE, 1'b0, 2'd0, 1'b0);

    // Run straight from IDLE, then overflow load and its clearing load
    do_run(3, 2'd3, 1'b0, 32'd0, 1'b0);
    rand_load(5);
    do_step(2'd0);
    rand_load(2);
    do_run(1, 2'd2, 1'b0, 32'd8, 1'b0);

    done = 1'b1;
    @(posedge clock); #1;
    @(posedge clock); #1;
  end

endmodule
